// File: rtl/alu_packet_engine.sv
// Framed byte-stream command engine: echo, add and (with ALU_MUL_EN defined) shift-add multiply.
// Without ALU_MUL_EN the multiply opcode is drained silently like any unknown opcode.
module alu_packet_engine #(
  parameter int unsigned OPERAND_W = 32,
  parameter logic [7:0]  OP_ECHO   = 8'hEC,
  parameter logic [7:0]  OP_ADD    = 8'hA0,
  parameter logic [7:0]  OP_MUL    = 8'h88
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic       led_o
);

  localparam int unsigned B   = OPERAND_W / 8;
  localparam int unsigned BCW = $clog2(B + 1);
  localparam int unsigned MCW = $clog2(OPERAND_W);
`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_HDR_OP, S_HDR_RSV, S_LEN_LO, S_LEN_HI, S_ECHO,
    S_OPERAND, S_MUL_RUN, S_RESULT_TX, S_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             op_q, op_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [BCW-1:0]         bidx_q, bidx_d;
  logic [OPERAND_W-1:0]   opnd_q, opnd_d;
  logic [OPERAND_W-1:0]   acc_q, acc_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   err_q, err_d;
  logic                   led_q, led_d;
`ifdef ALU_MUL_EN
  logic [OPERAND_W-1:0]   mcand_q, mcand_d;
  logic [MCW-1:0]         mcnt_q, mcnt_d;
`endif

  logic                   rx_ready_c;
  logic                   rx_acc_c;
  logic                   is_mul_c;
  logic [15:0]            len_c;
  logic [15:0]            pay_c;
  logic [OPERAND_W-1:0]   opnd_nxt_c;

  assign rx_ready_c = (state_q == S_ECHO) ? (!tx_valid_q || tx_ready_i)
                                          : !(state_q == S_MUL_RUN || state_q == S_RESULT_TX);
  assign rx_acc_c   = rx_valid_i && rx_ready_c;
  assign is_mul_c   = MUL_EN && (op_q == OP_MUL);
  assign len_c      = {rx_data_i, len_lo_q};
  assign pay_c      = len_c - 16'd4;
  // Little-endian operand: each new byte enters at the top and older bytes move down.
  assign opnd_nxt_c = OPERAND_W'({rx_data_i, opnd_q} >> 8);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_lo_d   = len_lo_q;
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    led_d      = led_q;
`ifdef ALU_MUL_EN
    mcand_d    = mcand_q;
    mcnt_d     = mcnt_q;
`endif
    if (tx_valid_q && tx_ready_i) tx_valid_d = 1'b0;

    unique case (state_q)
      S_HDR_OP: if (rx_acc_c) begin
        op_d    = rx_data_i;
        state_d = S_HDR_RSV;
      end
      S_HDR_RSV: if (rx_acc_c) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_acc_c) begin
        len_lo_d = rx_data_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_acc_c) begin
        cnt_d   = pay_c;
        bidx_d  = '0;
        acc_d   = is_mul_c ? OPERAND_W'(1) : '0;
        state_d = S_HDR_OP;
        if (len_c < 16'd4) begin
          err_d = 1'b1;
        end else if (op_q == OP_ECHO) begin
          if (pay_c == 16'd0) led_d = ~led_q;
          else                state_d = S_ECHO;
        end else if (op_q == OP_ADD || is_mul_c) begin
          if (pay_c == 16'd0) begin
            err_d = 1'b1;
          end else if ((pay_c % 16'(B)) != 16'd0) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_OPERAND;
          end
        end else if (pay_c == 16'd0) begin
          led_d = ~led_q;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_ECHO: if (rx_acc_c) begin
        tx_data_d  = rx_data_i;
        tx_valid_d = 1'b1;
        cnt_d      = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = S_HDR_OP;
          led_d   = ~led_q;
        end
      end
      S_OPERAND: if (rx_acc_c) begin
        opnd_d = opnd_nxt_c;
        cnt_d  = cnt_q - 16'd1;
        bidx_d = bidx_q + BCW'(1);
        if (bidx_q == BCW'(B - 1)) begin
          bidx_d = '0;
          if (is_mul_c) begin
`ifdef ALU_MUL_EN
            // Multiplier shifts right out of opnd_q; running product builds in acc_q.
            mcand_d = acc_q;
            acc_d   = '0;
            mcnt_d  = '0;
            state_d = S_MUL_RUN;
`endif
          end else begin
            acc_d = acc_q + opnd_nxt_c;
            if (cnt_q == 16'd1) state_d = S_RESULT_TX;
          end
        end
      end
      S_MUL_RUN: begin
`ifdef ALU_MUL_EN
        if (opnd_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        opnd_d  = opnd_q >> 1;
        mcnt_d  = mcnt_q + MCW'(1);
        if (mcnt_q == MCW'(OPERAND_W - 1)) state_d = (cnt_q == 16'd0) ? S_RESULT_TX : S_OPERAND;
`else
        state_d = S_HDR_OP;
`endif
      end
      S_RESULT_TX: if (!tx_valid_q || tx_ready_i) begin
        if (bidx_q != BCW'(B)) begin
          tx_data_d  = acc_q[7:0];
          tx_valid_d = 1'b1;
          acc_d      = acc_q >> 8;
          bidx_d     = bidx_q + BCW'(1);
        end else begin
          state_d = S_HDR_OP;
          led_d   = ~led_q;
        end
      end
      S_DRAIN: if (rx_acc_c) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = S_HDR_OP;
          led_d   = ~led_q;
        end
      end
      default: state_d = S_HDR_OP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_HDR_OP;
      op_q       <= '0;
      len_lo_q   <= '0;
      cnt_q      <= '0;
      bidx_q     <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q    <= '0;
      mcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_lo_q   <= len_lo_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      led_q      <= led_d;
`ifdef ALU_MUL_EN
      mcand_q    <= mcand_d;
      mcnt_q     <= mcnt_d;
`endif
    end
  end

  assign rx_ready_o = rx_ready_c;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != S_HDR_OP);
  assign err_o      = err_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_alu_packet_engine.sv
// Scoreboard bench for alu_packet_engine: directed packets, reset mid-response, then random packets.
module tb_alu_packet_engine;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned B = OPERAND_W / 8;
  typedef logic [7:0] bq_t[$];

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       tx_ready_i = 1'b0;
  logic       rx_ready_o, tx_valid_o, busy_o, err_o, led_o;
  logic [7:0] tx_data_o;

  alu_packet_engine #(.OPERAND_W(OPERAND_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .err_o(err_o), .led_o(led_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         err_seen = 0;
  int         exp_err = 0;
  logic       exp_led = 1'b0;
  int         tx_mode = 0;
  int         bp_cnt = 0;
  bit         echo_phase = 1'b0;
  logic       err_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // tx_ready_i pattern: 0 always ready, 1 random, 2 low 5 of every 6 cycles, 3 never ready.
  always @(posedge clk_i) begin
    #1;
    case (tx_mode)
      0: tx_ready_i = 1'b1;
      1: tx_ready_i = ($urandom_range(0, 2) != 0);
      2: begin bp_cnt = (bp_cnt + 1) % 6; tx_ready_i = (bp_cnt == 5); end
      default: tx_ready_i = 1'b0;
    endcase
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=none", tx_data_o);
        end else begin
          check("tx_byte", tx_data_o, exp_q.pop_front());
        end
      end
      if (echo_phase && tx_valid_o && !tx_ready_i) check("echo_rx_ready_bp", rx_ready_o, 0);
      if (err_o) begin
        err_seen++;
        check("err_pulse_width", err_prev, 0);
      end
      err_prev = err_o;
    end else begin
      err_prev = 1'b0;
    end
  end

  // Reference model: expected tx bytes, error flag and LED toggle for one packet.
  function automatic void model(input bq_t pkt, output bit err, output bit tog);
    logic [15:0]          len;
    int                   p;
    logic [7:0]           op;
    logic [OPERAND_W-1:0] r, o;
    bit                   mul_on;
`ifdef ALU_MUL_EN
    mul_on = 1'b1;
`else
    mul_on = 1'b0;
`endif
    err = 1'b0;
    tog = 1'b0;
    len = {pkt[3], pkt[2]};
    op  = pkt[0];
    if (len < 4) begin
      err = 1'b1;
      return;
    end
    p = int'(len) - 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < p; i++) exp_q.push_back(pkt[4 + i]);
      tog = 1'b1;
    end else if (op == 8'hA0 || (mul_on && op == 8'h88)) begin
      if (p == 0) begin
        err = 1'b1;
      end else if (p % B != 0) begin
        err = 1'b1;
        tog = 1'b1;
      end else begin
        r = (op == 8'hA0) ? '0 : OPERAND_W'(1);
        for (int k = 0; k < p / B; k++) begin
          o = '0;
          for (int j = 0; j < B; j++) o[8*j +: 8] = pkt[4 + k*B + j];
          r = (op == 8'hA0) ? r + o : r * o;
        end
        for (int j = 0; j < B; j++) exp_q.push_back(r[8*j +: 8]);
        tog = 1'b1;
      end
    end else begin
      tog = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, output int waits);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk_i);
      if (rx_ready_o) break;
      waits++;
      if (waits > 5000) begin
        checks++;
        failures++;
        $display("FAIL rx_accept_timeout actual=%0d required=<5000", waits);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 5000) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy_o) break;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
    check({name, "_err"}, err_seen, exp_err);
    check({name, "_led"}, led_o, exp_led);
  endtask

  task automatic run_packet(input bq_t pkt, input string name, input bit bp_chk,
                            input bit gaps, output int w8);
    bit e, t;
    int w;
    model(pkt, e, t);
    exp_err += int'(e);
    exp_led ^= t;
    w8 = -1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
      send_byte(pkt[i], w);
      if (i == 8) w8 = w;
      if (bp_chk && i == 3 && pkt.size() > 4) echo_phase = 1'b1;
    end
    echo_phase = 1'b0;
    wait_idle(name);
  endtask

  function automatic bq_t gen_packet();
    bq_t        pkt;
    int         kind, p;
    logic [7:0] op;
    logic [15:0] len;
    kind = $urandom_range(0, 8);
    p = 0;
    op = 8'hEC;
    case (kind)
      0: begin op = 8'hEC; p = $urandom_range(0, 6); end
      1, 2: begin op = 8'hA0; p = B * $urandom_range(1, 3); end
      3, 4: begin op = 8'h88; p = B * $urandom_range(1, 3); end
      5: begin
        op = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'h88;
        p = B * $urandom_range(0, 2) + $urandom_range(1, B - 1);
      end
      6: begin
        do op = 8'($urandom); while (op == 8'hEC || op == 8'hA0 || op == 8'h88);
        p = $urandom_range(0, 5);
      end
      8: begin op = 8'hA0; p = 0; end
      default: ;
    endcase
    len = (kind == 7) ? 16'($urandom_range(0, 3)) : 16'(p + 4);
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    if (kind != 7)
      for (int i = 0; i < p; i++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    return pkt;
  endfunction

  initial begin
    bq_t pkt;
    int  w8;
    int  n;
    #12;
    check("rst_rx_ready", rx_ready_o, 1);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_led", led_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    tx_mode = 0;
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    run_packet(pkt, "echo", 1'b0, 1'b0, w8);
    tx_mode = 2;
    run_packet(pkt, "echo_bp", 1'b1, 1'b0, w8);

    tx_mode = 0;
    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, "add_wrap", 1'b0, 1'b0, w8);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, "mul", 1'b0, 1'b0, w8);
`ifdef ALU_MUL_EN
    check("mul_stall_cycles", w8, OPERAND_W);
`else
    check("mul_drain_no_stall", w8, 0);
`endif

    pkt = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_packet(pkt, "malformed", 1'b0, 1'b0, w8);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_packet(pkt, "echo_after_err", 1'b0, 1'b0, w8);

    // Reset while the result is waiting on a stalled transmitter.
    tx_mode = 3;
    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], w8);
    n = 0;
    while (!tx_valid_o && n < 100) begin @(negedge clk_i); n++; end
    check("rst_mid_tx_pending", tx_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_tx_valid", tx_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_led", led_o, 0);
    exp_led = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tx_mode = 0;
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hC3, 8'h3C};
    run_packet(pkt, "echo_after_rst", 1'b0, 1'b0, w8);

    for (int k = 0; k < 40; k++) begin
      tx_mode = $urandom_range(0, 2);
      pkt = gen_packet();
      run_packet(pkt, "rand", 1'b0, 1'b1, w8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
